seg_scan_ctrl: RTL and testbench

- Scan controller for the 8-digit seven-segment display, directly upstream of the 8:1 nibble mux.
- Latches the 32-bit display word and generates the 3-bit digit select (`count`) that the mux uses to pick a nibble.
- Drives the active-low anode enables, with a guard (blank) interval on each digit change to prevent ghosting.

---
 rtl/seg_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for an 8-digit seven-segment display.
//
// This block holds the display word and produces the digit select that drives
// the downstream 8:1 nibble mux. It also drives the active-low anode enables.
// Each digit slot lasts CLK_DIV cycles and starts with GUARD blank cycles. The
// blank interval lets the mux output settle before a digit is lit, which
// prevents ghosting.
//
// Optional build macro:
//   LZB_EN - leading-zero blanking. Digits above the highest nonzero nibble
//            of disp_val stay dark. Digit 0 always lights.
//
// Reset is synchronous and active-high. Every output is registered.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | scan disabled, all anodes off, count held
// S_GUARD | start of a slot, all anodes off while the mux settles
// S_ON    | anode of digit `count` driven low until the slot boundary

module seg_scan_ctrl #(
    parameter int CLK_DIV    = 100000,
    parameter int GUARD      = 8,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] value_in,
    output logic [31:0] disp_val,
    output logic [2:0]  count,
    output logic [7:0]  an,
    output logic        slot_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
    localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [PW-1:0] presc;
    logic [PW-1:0] prescNext;
    logic          boundary;
    logic [2:0]    countNext;
    logic [31:0]   dispNext;
    logic [7:0]    anNext;
    logic          digitLit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: prescaler stepping, slot boundary detection and
    // state transitions. Dropping en forces IDLE from any state.
    always_comb begin
        stateNext = state;
        prescNext = presc;
        boundary  = 1'b0;
        if (!en) begin
            stateNext = S_IDLE;
            prescNext = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Resume with a fresh slot. count is kept, so the scan
                    // continues on the digit where it stopped.
                    prescNext = '0;
                    stateNext = S_GUARD;
                end
                S_GUARD: begin
                    if (presc == PRESC_LAST) begin
                        prescNext = '0;
                        boundary  = 1'b1;
                    end else begin
                        prescNext = presc + 1'b1;
                    end
                    if (prescNext == GUARD_END) begin
                        stateNext = S_ON;
                    end
                end
                S_ON: begin
                    if (presc == PRESC_LAST) begin
                        prescNext = '0;
                        boundary  = 1'b1;
                        stateNext = S_GUARD;
                    end else begin
                        prescNext = presc + 1'b1;
                    end
                end
                default: begin
                    stateNext = S_IDLE;
                    prescNext = '0;
                end
            endcase
        end
    end

    // Digit select advance: the counter moves only on a slot boundary. On
    // that edge the anodes go to FF, so the mux changes while all digits are dark.
    always_comb begin
        countNext = count;
        if (boundary) begin
            countNext = (count == LAST_DIGIT) ? 3'd0 : count + 3'd1;
        end
    end

    // Next display word. A load applies in any state, including mid-slot.
    always_comb begin
        dispNext = load ? value_in : disp_val;
    end

`ifdef LZB_EN
    logic [2:0] hiNext;

    // Index of the highest nonzero nibble of the word that will be shown.
    // The index never drops below 0, so digit 0 always lights.
    always_comb begin
        hiNext = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (dispNext[4*k +: 4] != 4'h0) begin
                hiNext = 3'(k);
            end
        end
    end

    // Digit lights only at or below the highest significant nibble.
    always_comb begin
        digitLit = (countNext <= hiNext);
    end
`else
    // Every digit lights in its own slot.
    always_comb begin
        digitLit = 1'b1;
    end
`endif

    // Output decode from the next state. The result is registered below, so
    // an, count and disp_val always change on the same edge.
    always_comb begin
        anNext = 8'hFF;
        if (stateNext == S_ON && digitLit) begin
            anNext = ~(8'h01 << countNext);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            count     <= 3'd0;
            disp_val  <= 32'h0;
            an        <= 8'hFF;
            slot_tick <= 1'b0;
        end else begin
            presc     <= prescNext;
            count     <= countNext;
            disp_val  <= dispNext;
            an        <= anNext;
            slot_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl. The bench runs two instances with different
// parameter sets against a slot-position reference model. Directed scenarios
// are followed by randomized enable, load and reset traffic.
module tb_seg_scan_ctrl;

    localparam int DIV_A = 4, GRD_A = 1, ND_A = 8;
    localparam int DIV_B = 6, GRD_B = 2, ND_B = 5;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [31:0] valueIn;

    logic [31:0] dispA, dispB;
    logic [2:0]  countA, countB;
    logic [7:0]  anA, anB;
    logic        tickA, tickB;

    int nAsserts = 0;
    int nFails   = 0;
    logic checking = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLK_DIV(DIV_A), .GUARD(GRD_A), .NUM_DIGITS(ND_A)) dutA (
        .clk(clk), .rst(rst), .en(en), .load(load), .value_in(valueIn),
        .disp_val(dispA), .count(countA), .an(anA), .slot_tick(tickA)
    );

    seg_scan_ctrl #(.CLK_DIV(DIV_B), .GUARD(GRD_B), .NUM_DIGITS(ND_B)) dutB (
        .clk(clk), .rst(rst), .en(en), .load(load), .value_in(valueIn),
        .disp_val(dispB), .count(countB), .an(anB), .slot_tick(tickB)
    );

    // Reference model: pos is the cycle index within the current slot.
    // A value of -1 means the scan is disabled.
    typedef struct {
        int          pos;
        int          cnt;
        logic [31:0] disp;
        logic        tick;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdlStep(mdl_t m, logic r, logic e, logic l,
                                     logic [31:0] v, int div, int nd);
        mdl_t n = m;
        if (r) begin
            n.pos = -1; n.cnt = 0; n.disp = 32'h0; n.tick = 1'b0;
        end else begin
            if (l) n.disp = v;
            n.tick = 1'b0;
            if (!e) begin
                n.pos = -1;
            end else if (m.pos < 0) begin
                n.pos = 0;
            end else if (m.pos == div - 1) begin
                n.pos  = 0;
                n.cnt  = (m.cnt + 1) % nd;
                n.tick = 1'b1;
            end else begin
                n.pos = m.pos + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] mdlAn(mdl_t m, int grd);
        logic lit = 1'b1;
`ifdef LZB_EN
        int hi = 0;
        for (int k = 1; k < 8; k++) if (m.disp[4*k +: 4] != 4'h0) hi = k;
        lit = (m.cnt <= hi);
`endif
        if (m.pos < grd || !lit) return 8'hFF;
        return ~(8'h01 << m.cnt);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model on every active edge, using the same inputs the DUTs sample.
    always @(posedge clk) begin
        ma = mdlStep(ma, rst, en, load, valueIn, DIV_A, ND_A);
        mb = mdlStep(mb, rst, en, load, valueIn, DIV_B, ND_B);
    end

    // Compare both instances against the model on every cycle.
    always @(negedge clk) begin
        if (checking) begin
            chk("A_disp",  dispA,             ma.disp);
            chk("A_count", 32'(countA),       32'(ma.cnt));
            chk("A_an",    32'(anA),          32'(mdlAn(ma, GRD_A)));
            chk("A_tick",  32'(tickA),        32'(ma.tick));
            chk("A_onehot", 32'($countones(~anA) <= 1), 32'd1);
            chk("B_disp",  dispB,             mb.disp);
            chk("B_count", 32'(countB),       32'(mb.cnt));
            chk("B_an",    32'(anB),          32'(mdlAn(mb, GRD_B)));
            chk("B_tick",  32'(tickB),        32'(mb.tick));
            chk("B_onehot", 32'($countones(~anB) <= 1), 32'd1);
        end
    end

    initial begin
        logic [7:0] anExp [6];
        logic [2:0] cntExp [6];
        logic       tickExp [6];
        int  seen;
        logic found;

        anExp   = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD};
        cntExp  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
        tickExp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        ma = '{pos: -1, cnt: 0, disp: 32'h0, tick: 1'b0};
        mb = '{pos: -1, cnt: 0, disp: 32'h0, tick: 1'b0};
        rst = 1'b1; en = 1'b0; load = 1'b0; valueIn = 32'hDEAD_BEEF;

        // Reset for two cycles.
        repeat (2) @(negedge clk);
        checking = 1'b1;
        chk("rst_an",    32'(anA),    32'hFF);
        chk("rst_count", 32'(countA), 32'd0);
        chk("rst_disp",  dispA,       32'h0);

        // First slots after enable: guard, lit x3, guard with tick, next digit.
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("start_an",    32'(anA),    32'(anExp[i]));
            chk("start_count", 32'(countA), 32'(cntExp[i]));
            chk("start_tick",  32'(tickA),  32'(tickExp[i]));
        end

        // Full scan: the next seven ticks should show count 2..7, then 0.
        seen = 0;
        for (int c = 0; c < 40 && seen < 7; c++) begin
            @(negedge clk);
            if (tickA) begin
                chk("scan_seq", 32'(countA), 32'((seen + 2) % 8));
                seen++;
            end
        end
        chk("scan_ticks", 32'(seen), 32'd7);

        // Mid-slot load.
        repeat (2) @(negedge clk);
        load = 1'b1; valueIn = 32'h1234ABCD;
        @(negedge clk);
        load = 1'b0;
        chk("load_disp", dispA, 32'h1234ABCD);

        // Drop en while digit 2 is lit.
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (anA == 8'hFB) found = 1'b1;
        end
        chk("wait_an_FB", 32'(found), 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_an",    32'(anA),    32'hFF);
        chk("dis_count", 32'(countA), 32'd2);
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("reen_guard", 32'(anA), 32'hFF);
        @(negedge clk);
        chk("reen_an", 32'(anA), 32'hFB);

        // Reset while count is 5.
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (countA == 3'd5) found = 1'b1;
        end
        chk("wait_count5", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_count", 32'(countA), 32'd0);
        chk("mid_rst_an",    32'(anA),    32'hFF);
        chk("mid_rst_disp",  dispA,       32'h0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 19) != 0);
            load    = ($urandom_range(0, 9) == 0);
            valueIn = $urandom >> (4 * $urandom_range(0, 7));
            rst     = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        checking = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
